// File: rtl/ext_pkg.sv
// Immediate-extension mode encodings and the shared extension function.
// Used by both the pipelined extender and the single-cycle core.
package ext_pkg;

    localparam logic [1:0] MODE_ZEXT     = 2'd0;
    localparam logic [1:0] MODE_SEXT     = 2'd1;
    localparam logic [1:0] MODE_UPPER    = 2'd2;
    localparam logic [1:0] MODE_SEXT_SHL = 2'd3;

    localparam int unsigned EXT_MAX_W = 64;

    typedef logic [EXT_MAX_W-1:0] ext_word_t;

    // Widths are run-time arguments so one function serves every caller;
    // callers keep the low out_w bits of the result.
    function automatic ext_word_t ext_imm(
        input ext_word_t   imm,
        input logic [1:0]  mode,
        input int unsigned in_w,
        input int unsigned out_w,
        input int unsigned shift
    );
        ext_word_t mask;
        ext_word_t zext;
        ext_word_t sext;
        ext_word_t res;
        mask = ~(~ext_word_t'(0) << in_w);
        zext = imm & mask;
        sext = imm[in_w-1] ? (zext | ~mask) : zext;
        unique case (mode)
            MODE_ZEXT:  res = zext;
            MODE_SEXT:  res = sext;
            MODE_UPPER: res = zext << (out_w - in_w);
            default:    res = sext << shift;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ext_pipe_slice.sv
// One elastic register slice: accepts when empty or when downstream drains.
// Data holds while valid and stalled.
module ext_pipe_slice #(
    parameter int DW = 37
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    assign up_ready = !valid_q || dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (up_ready) begin
            valid_q <= up_valid;
            if (up_valid) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Multi-mode immediate extender followed by STAGES elastic slices.
// The tag rides alongside the result so consumers can match instructions.
module imm_extend_pipe
    import ext_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 2,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int DW = OUT_W + TAG_W;

    ext_word_t        ext_full;
    logic             unused_hi;
    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    logic [DW-1:0]    dat [STAGES+1];

    assign ext_full = ext_imm(ext_word_t'(in_imm), in_mode,
                              IN_W, OUT_W, SHIFT);
    assign unused_hi = ^ext_full[EXT_MAX_W-1:OUT_W];

    assign vld[0]      = in_valid;
    assign dat[0]      = {ext_full[OUT_W-1:0], in_tag};
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        ext_pipe_slice #(
            .DW(DW)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (vld[i]),
            .up_ready (rdy[i]),
            .up_data  (dat[i]),
            .dn_valid (vld[i+1]),
            .dn_ready (rdy[i+1]),
            .dn_data  (dat[i+1])
        );
    end

    assign out_valid = vld[STAGES];
    assign out_imm   = dat[STAGES][DW-1:TAG_W];
    assign out_tag   = dat[STAGES][TAG_W-1:0];
    assign busy      = |vld[STAGES:1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomised and directed bench for imm_extend_pipe against a queue model,
// plus a second instance at STAGES=1, IN_W=OUT_W=32, SHIFT=0.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;
    logic        busy;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [31:0] b_in_imm = '0;
    logic [1:0]  b_in_mode = '0;
    logic [4:0]  b_in_tag = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [31:0] b_out_imm;
    logic [4:0]  b_out_tag;
    logic        b_busy;

    always #5 clk = ~clk;

    imm_extend_pipe u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .busy(busy)
    );

    imm_extend_pipe #(
        .IN_W(32), .OUT_W(32), .SHIFT(0), .STAGES(1), .TAG_W(5)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_imm(b_in_imm), .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_tag(b_out_tag), .busy(b_busy)
    );

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic [4:0]  seen_tags[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          out_cnt = 0;
    bit          lat_chk = 0;
    bit          rnd_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain arithmetic reading of the four modes for 16->32, shift 2.
    function automatic logic [31:0] model(input logic [15:0] imm,
                                          input logic [1:0] m);
        int s;
        s = int'($signed(imm));
        case (m)
            2'd0:    return 32'(imm);
            2'd1:    return 32'(s);
            2'd2:    return 32'(imm) * 32'd65536;
            default: return 32'(s * 4);
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_cnt++;
                seen_tags.push_back(out_tag);
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(out_tag), 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk("out_imm", 64'(out_imm), 64'(e.imm));
                    chk("out_tag", 64'(out_tag), 64'(e.tag));
                    if (lat_chk)
                        chk("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                e.imm = model(in_imm, in_mode);
                e.tag = in_tag;
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [15:0] imm, input logic [1:0] m,
                        input logic [4:0] tag);
        bit ok;
        int n;
        in_imm   = imm;
        in_mode  = m;
        in_tag   = tag;
        in_valid = 1'b1;
        ok = 0;
        n  = 0;
        while (!ok && n < 500) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] lit [4];
    int          base_acc;
    int          base_out;

    initial begin
        lit[0] = 32'h0000_8004;
        lit[1] = 32'hFFFF_8004;
        lit[2] = 32'h8004_0000;
        lit[3] = 32'hFFFE_0010;

        // Reset with in_valid high
        in_valid = 1'b1;
        in_imm   = 16'h1234;
        tick(2);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_no_out", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Model pinned against hand-computed values
        for (int m = 0; m < 4; m++)
            chk("model_lit", 64'(model(16'h8004, 2'(m))), 64'(lit[m]));

        // Each mode, single item, exact 2-cycle latency
        lat_chk = 1;
        for (int m = 0; m < 4; m++) begin
            in_imm   = 16'h8004;
            in_mode  = 2'(m);
            in_tag   = 5'(10 + m);
            in_valid = 1'b1;
            @(negedge clk);
            chk("mode_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk("mode_lat_early", 64'(out_valid), 64'd0);
            @(posedge clk);
            @(negedge clk);
            chk("mode_valid", 64'(out_valid), 64'd1);
            chk("mode_imm", 64'(out_imm), 64'(lit[m]));
            chk("mode_tag", 64'(out_tag), 64'(10 + m));
            @(posedge clk);
            #1;
        end
        lat_chk = 0;
        tick(2);

        // Backpressure: six tags, consumer stalled
        seen_tags.delete();
        out_ready = 1'b0;
        base_acc  = acc_cnt;
        fork
            begin
                for (int t = 1; t <= 6; t++)
                    send(16'(t * 3), 2'(t % 4), 5'(t));
            end
            begin
                tick(6);
                @(negedge clk);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_accepts", 64'(acc_cnt - base_acc), 64'd2);
                chk("bp_busy", 64'(busy), 64'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        tick(5);
        chk("bp_count", 64'(seen_tags.size()), 64'd6);
        for (int t = 0; t < 6 && t < seen_tags.size(); t++)
            chk("bp_order", 64'(seen_tags[t]), 64'(t + 1));

        // Full pipe, simultaneous push and pop
        out_ready = 1'b0;
        send(16'h0001, 2'd1, 5'd20);
        send(16'h0002, 2'd1, 5'd21);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        base_acc  = acc_cnt;
        base_out  = out_cnt;
        fork
            for (int k = 0; k < 10; k++)
                send(16'($urandom), 2'($urandom), 5'(k));
            repeat (10) begin
                @(negedge clk);
                chk("sim_busy", 64'(busy), 64'd1);
            end
        join
        chk("sim_in", 64'(acc_cnt - base_acc), 64'd10);
        chk("sim_out", 64'(out_cnt - base_out), 64'd10);
        tick(4);
        chk("sim_drain", 64'(q.size()), 64'd0);

        // Mid-operation reset
        out_ready = 1'b0;
        send(16'h00AA, 2'd0, 5'd30);
        send(16'h00BB, 2'd0, 5'd31);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        base_out  = out_cnt;
        out_ready = 1'b1;
        tick(6);
        chk("mrst_no_emit", 64'(out_cnt - base_out), 64'd0);

        // Randomised traffic with random backpressure
        lat_chk  = 0;
        rnd_done = 0;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    if ($urandom_range(0, 3) == 0) tick(1);
                    send(16'($urandom), 2'($urandom), 5'($urandom));
                end
                rnd_done = 1;
            end
            while (!rnd_done) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        tick(6);
        chk("rnd_drain", 64'(q.size()), 64'd0);
        chk("rnd_idle", 64'(busy), 64'd0);

        // One-stage, full-width instance: all modes pass through
        for (int m = 0; m < 4; m++) begin
            b_in_imm   = 32'h8000_0001;
            b_in_mode  = 2'(m);
            b_in_tag   = 5'(m + 1);
            b_in_valid = 1'b1;
            @(negedge clk);
            chk("w32_in_ready", 64'(b_in_ready), 64'd1);
            @(posedge clk);
            #1;
            b_in_valid = 1'b0;
            @(negedge clk);
            chk("w32_valid", 64'(b_out_valid), 64'd1);
            chk("w32_imm", 64'(b_out_imm), 64'h8000_0001);
            chk("w32_tag", 64'(b_out_tag), 64'(m + 1));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("w32_idle", 64'(b_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
